// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the register file's single write port between NUM_REQ
//            writeback requesters using a round-robin arbiter with a
//            valid/ready handshake. The winning request is written through
//            a one-cycle registered output stage. A per-register pending-write
//            scoreboard tracks reservations made at issue so that the issue
//            stage can query source registers for outstanding writes.
// Ports    : clk, rst_n             - clock, async active-low reset
//            req_valid/req_ready   - per-requester handshake (ready is comb.)
//            req_addr/req_data     - packed per-requester index and data
//            rf_reg_write/rf_write_register/rf_write_data
//                                  - registered register-file write port
//            rsv_valid/rsv_addr    - issue-stage destination reservation
//            rsv_stall             - reservation refused (count saturated)
//            chk_addr_1/2, chk_pending_1/2
//                                  - source-register hazard queries
//            sb_err                - sticky: commit to a register with no
//                                    pending write
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        rf_reg_write,
  output logic [ADDR_W-1:0]           rf_write_register,
  output logic [DATA_W-1:0]           rf_write_data,
  input  logic                        rsv_valid,
  input  logic [ADDR_W-1:0]           rsv_addr,
  output logic                        rsv_stall,
  input  logic [ADDR_W-1:0]           chk_addr_1,
  input  logic [ADDR_W-1:0]           chk_addr_2,
  output logic                        chk_pending_1,
  output logic                        chk_pending_2,
  output logic                        sb_err
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  // --------------------------------------------------------------------------
  // Round-robin arbiter
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_vld;
  logic [PTR_W:0]   cand;   // one extra bit so ptr+k cannot overflow

  always_comb begin
    req_ready = '0;
    grant_idx = ptr;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_vld && req_valid[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Pointer moves past the winner only on an actual handshake; ready is only
  // raised for a valid requester, so grant_vld is the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_vld) begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + PTR_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered write stage: drains every cycle, address/data hold when idle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_write      <= 1'b0;
      rf_write_register <= '0;
      rf_write_data     <= '0;
    end else begin
      rf_reg_write <= grant_vld;
      if (grant_vld) begin
        rf_write_register <= req_addr[grant_idx*ADDR_W +: ADDR_W];
        rf_write_data     <= req_data[grant_idx*DATA_W +: DATA_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending-write scoreboard (2-bit saturating count per register)
  // --------------------------------------------------------------------------
  logic [NREG-1:0][1:0] cnt;
  logic [NREG-1:0]      inc_vec;
  logic [NREG-1:0]      dec_vec;
  logic                 commit_err;

  assign rsv_stall     = rsv_valid && (cnt[rsv_addr] == 2'd3);
  assign chk_pending_1 = (cnt[chk_addr_1] != 2'd0);
  assign chk_pending_2 = (cnt[chk_addr_2] != 2'd0);
  // Commit is the edge where the register file captures the write, so the
  // count drops on the same edge that rf_reg_write is seen high.
  assign commit_err    = rf_reg_write && (cnt[rf_write_register] == 2'd0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (rsv_valid && !rsv_stall) begin
      inc_vec[rsv_addr] = 1'b1;
    end
    if (rf_reg_write) begin
      dec_vec[rf_write_register] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        // Reserve and commit together leave the count unchanged.
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   cnt[r] <= cnt[r] + 2'd1;
          2'b01:   if (cnt[r] != 2'd0) cnt[r] <= cnt[r] - 2'd1;
          default: cnt[r] <= cnt[r];
        endcase
      end
      if (commit_err) begin
        sb_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback requesters (e.g. ALU, load unit) using round-robin arbitration and a valid/ready handshake.
- Drives the register file's write signals from a registered output stage.
- Keeps a per-register pending-write scoreboard. Issue logic reserves a destination at dispatch and queries source registers for hazards.
- Sits between the execute/memory writeback paths and the register file.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..4 supported)
DATA_W, 64, writeback data width
ADDR_W, 5, register index width (32 registers)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester grant (combinational, one-hot or zero)
req_addr  input  NUM_REQ*ADDR_W  destination index; requester i uses slice [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  write data; requester i uses slice [i*DATA_W +: DATA_W]
rf_reg_write  output  1  register file write enable
rf_write_register  output  ADDR_W  register file write index
rf_write_data  output  DATA_W  register file write data
rsv_valid  input  1  reserve destination rsv_addr (issue stage)
rsv_addr  input  ADDR_W  register being reserved
rsv_stall  output  1  reservation refused: counter for rsv_addr saturated
chk_addr_1  input  ADDR_W  source register 1 hazard query
chk_addr_2  input  ADDR_W  source register 2 hazard query
chk_pending_1  output  1  chk_addr_1 has a write outstanding
chk_pending_2  output  1  chk_addr_2 has a write outstanding
sb_err  output  1  sticky flag: a commit hit a register with zero pending count

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_reg_write=0, rf_write_register=0, rf_write_data=0.
  - Round-robin pointer=0, all pending counters=0, sb_err=0.
  - An in-flight output write is dropped.
  - Outputs stay at these values while rst_n is low.
  - First grant is possible in the first cycle after rst_n rises.
- Arbitration (combinational, at most one grant per cycle):
  - Search from pointer p upward with wrap-around. The first i with req_valid[i]=1 gets req_ready[i]=1; all others get 0.
  - No valid requests: req_ready=0 and the pointer is unchanged.
  - A handshake occurs when req_valid[i]&req_ready[i]. On that edge the pointer becomes (i+1) mod NUM_REQ.
  - A requester must hold valid/addr/data stable until ready. Dropping valid before grant is legal; nothing is written.
- Output stage, latency 1:
  - Handshake in cycle k: in cycle k+1, rf_reg_write=1 and rf_write_register/rf_write_data equal the granted addr/data.
  - Data is forwarded unmodified at full DATA_W.
  - No handshake in cycle k: rf_reg_write=0 in k+1 and addr/data hold their previous values.
  - The stage drains every cycle (no backpressure), so back-to-back grants give a write every cycle.
- Scoreboard: 2-bit pending count per register, range 0..3.
  - Reserve: rsv_valid with count<3 increments at the edge. If count==3, rsv_stall=1 (combinational) and the count is unchanged.
  - Commit: rf_reg_write=1 decrements count[rf_write_register] at that same edge, i.e. the edge where the register file captures the data.
  - Commit with count==0: count stays 0 and sb_err is set; it clears only on reset.
  - Reserve and commit to the same register on the same edge: net count unchanged. rsv_stall still follows the pre-edge count.
  - chk_pending_n = (count[chk_addr_n] != 0), combinational. It deasserts the cycle after the committing edge, when the value is readable.
  - Register 0 is tracked like any other register; there is no special case.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high; no req_valid -> all outputs 0, req_ready=0, sb_err=0.
- Single write: req0 addr=7, data=0x0000_0000_DEAD_BEEF in cycle k -> req_ready[0]=1 in k; rf_reg_write=1, rf_write_register=7, rf_write_data=0xDEADBEEF in k+1; rf_reg_write=0 in k+2.
- Fairness: both requesters held valid for 4 cycles (req0 addr=1, req1 addr=2) -> grants alternate 0,1,0,1; rf_write_register sequence 1,2,1,2 on consecutive cycles.
- Scoreboard hazard: reserve r5 at edge e0, then chk_addr_1=5 -> chk_pending_1=1. req1 writes r5 -> chk_pending_1 stays 1 through the rf_reg_write cycle and reads 0 the following cycle.
- Saturation and error: reserve r9 four times -> 4th cycle rsv_stall=1 and count stays 3. Separately, commit to an unreserved r12 -> sb_err=1 and stays 1 until reset.
- Reset mid-operation: assert rst_n low in the same cycle rf_reg_write=1 for r3 with r3 reserved -> rf_reg_write drops to 0 immediately; after release chk_pending for r3=0 and pointer=0 (req0 wins a tie).
